// File: rtl/pc_pkg.sv
// Shared instruction field positions and helpers for the program-counter unit.
package pc_pkg;

    localparam int IMM_LSB = 0;
    localparam int IMM_MSB = 15;
    localparam int TGT_MSB = 25;
    localparam int RS_LSB  = 21;
    localparam int RS_MSB  = 25;

    localparam logic [4:0] RA_REG = 5'd31;

    // Wide enough for any supported XLEN; callers keep the low XLEN bits.
    function automatic logic [63:0] sext16(input logic [15:0] imm);
        return {{48{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry, pop+push replaces the top.
module return_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [XLEN-1:0]          push_data,
    output logic [XLEN-1:0]          top,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_top;

    // ptr names the next free slot, so the top entry sits one below it.
    assign ptr_top = ptr - 1'b1;
    assign top     = mem[ptr_top];
    assign empty   = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && pop && !empty) begin
            mem[ptr_top] <= push_data;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + 1'b1;
            if (count != (PW+1)'(DEPTH)) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr   <= ptr_top;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with branch/jump/jr target selection and misalignment flag.
// Define PC_RAS_EN to add a return-address stack and the ras_mismatch predictor check.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [31:0]     instruction,
    input  logic            Jump,
    input  logic            Branch,
    input  logic            Bne,
    input  logic            JumpReg,
    input  logic            Link,
    input  logic            zero,
    input  logic [XLEN-1:0] rs_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] link_addr,
    output logic            redirect,
    output logic            misalign_err,
    output logic            ras_mismatch
);

    logic [63:0]     imm_sext;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] j_tgt;
    logic [XLEN-1:0] jr_tgt;
    logic [XLEN-1:0] next_pc;
    logic            taken;

    localparam int unused_ras_depth = RAS_DEPTH;

    assign pc_plus4  = pc + XLEN'(4);
    assign link_addr = pc_plus4;
    assign imm_sext  = sext16(instruction[IMM_MSB:IMM_LSB]);
    assign br_tgt    = pc_plus4 + (imm_sext[XLEN-1:0] << 2);
    assign jr_tgt    = {rs_data[XLEN-1:2], 2'b00};
    assign taken     = Branch & (zero ^ Bne);

    generate
        if (XLEN > 28) begin : g_region
            assign j_tgt = {pc_plus4[XLEN-1:28], instruction[TGT_MSB:0], 2'b00};
        end else begin : g_no_region
            assign j_tgt = {instruction[TGT_MSB:0], 2'b00};
        end
    endgenerate

    always_comb begin
        next_pc = pc_plus4;
        if (JumpReg) begin
            next_pc = jr_tgt;
        end else if (Jump) begin
            next_pc = j_tgt;
        end else if (taken) begin
            next_pc = br_tgt;
        end
    end

    assign redirect = !stall && (next_pc != pc_plus4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            if (!stall) begin
                pc <= next_pc;
            end
            misalign_err <= JumpReg & !stall & (|rs_data[1:0]);
        end
    end

`ifdef PC_RAS_EN
    logic                      ras_push;
    logic                      ras_pop;
    logic                      ras_empty;
    logic [XLEN-1:0]           ras_top;
    logic [$clog2(RAS_DEPTH):0] unused_ras_count;
    logic                      unused_bits;

    assign unused_bits = ^instruction[31:26];
    assign ras_push    = Link & (Jump | JumpReg) & !stall;
    assign ras_pop     = JumpReg & (instruction[RS_MSB:RS_LSB] == RA_REG) & !stall;

    return_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .count     (unused_ras_count)
    );

    // The prediction is only checked; jr_tgt stays the architectural target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_mismatch <= 1'b0;
        end else begin
            ras_mismatch <= ras_pop & !ras_empty & (ras_top != jr_tgt);
        end
    end
`else
    logic unused_bits;

    assign unused_bits  = ^{instruction[31:26], Link};
    assign ras_mismatch = 1'b0;
`endif

endmodule
